// File: rtl/instruction_loader.sv
// UART program loader: receives framed 8N1 bytes, assembles little-endian words and writes them
// into instruction memory, holding the core in reset until a checksum-verified frame completes.
module instruction_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned XLEN         = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx,
    input  logic                  i_load_enable,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [XLEN-1:0]       o_mem_data,
    output logic                  o_mem_wren,
    output logic                  o_core_reset,
    output logic                  o_busy,
    output logic                  o_error
);

    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned WcW   = ADDR_WIDTH + 1;
    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;
    typedef enum logic [1:0] {StIdle, StLen, StData, StCheck} st_state_t;

    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t       r_rx_state;
    logic [CntW-1:0] r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_byte_valid;
    logic            r_frame_err;

    st_state_t       r_state;
    logic [WcW-1:0]  r_len;
    logic [WcW-1:0]  r_word_cnt;
    logic [1:0]      r_byte_idx;
    logic [XLEN-9:0] r_word;
    logic [7:0]      r_csum;
    logic            r_hold;

    // Byte receiver; r_shift holds the received byte while r_byte_valid is high.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RxIdle;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            unique case (r_rx_state)
                RxIdle: begin
                    if (!r_rx_sync && r_rx_prev) begin
                        r_rx_state <= RxStart;
                        r_clk_cnt  <= '0;
                    end
                end
                RxStart: begin
                    if (r_clk_cnt == CntHalf) begin
                        r_clk_cnt  <= '0;
                        r_bit_idx  <= '0;
                        r_rx_state <= r_rx_sync ? RxIdle : RxData;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (r_clk_cnt == CntFull) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) r_rx_state <= RxStop;
                        else                   r_bit_idx  <= r_bit_idx + 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (r_clk_cnt == CntFull) begin
                        r_clk_cnt    <= '0;
                        r_rx_state   <= RxIdle;
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= !r_rx_sync;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Frame parser. r_hold remembers whether the core must stay in reset between frames.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= StIdle;
            r_len         <= '0;
            r_word_cnt    <= '0;
            r_byte_idx    <= '0;
            r_word        <= '0;
            r_csum        <= '0;
            r_hold        <= 1'b0;
            o_mem_address <= '0;
            o_mem_data    <= '0;
            o_mem_wren    <= 1'b0;
            o_core_reset  <= 1'b1;
            o_error       <= 1'b0;
        end else begin
            o_mem_wren   <= 1'b0;
            o_core_reset <= r_hold;
            if (r_frame_err && r_state != StIdle) begin
                o_error <= 1'b1;
                r_state <= StIdle;
            end else if (r_byte_valid) begin
                unique case (r_state)
                    StIdle: begin
                        if (r_shift == 8'hA5 && i_load_enable) begin
                            r_state      <= StLen;
                            o_error      <= 1'b0;
                            r_csum       <= '0;
                            r_word_cnt   <= '0;
                            r_byte_idx   <= '0;
                            r_hold       <= 1'b1;
                            o_core_reset <= 1'b1;
                        end
                    end
                    StLen: begin
                        if (r_shift == 8'd0 || 32'(r_shift) > Depth) begin
                            o_error <= 1'b1;
                            r_state <= StIdle;
                        end else begin
                            r_len   <= WcW'(r_shift);
                            r_state <= StData;
                        end
                    end
                    StData: begin
                        r_csum     <= r_csum ^ r_shift;
                        r_word     <= {r_shift, r_word[XLEN-9:8]};
                        r_byte_idx <= r_byte_idx + 1'b1;
                        if (r_byte_idx == 2'd3) begin
                            o_mem_wren    <= 1'b1;
                            o_mem_data    <= {r_shift, r_word};
                            o_mem_address <= r_word_cnt[ADDR_WIDTH-1:0];
                            r_word_cnt    <= r_word_cnt + 1'b1;
                            if (r_word_cnt + 1'b1 == r_len) r_state <= StCheck;
                        end
                    end
                    StCheck: begin
                        r_state <= StIdle;
                        if (r_shift == r_csum) begin
                            o_error      <= 1'b0;
                            r_hold       <= 1'b0;
                            o_core_reset <= 1'b0;
                        end else begin
                            o_error <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign o_busy = (r_state != StIdle);

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: table of UART frames with expected writes and end status,
// plus hand-written sequences for mid-frame reset and a maximum-length frame.
module tb_instruction_loader;

    localparam int unsigned Cpb = 4;

    logic        clk = 1'b0;
    logic        i_reset, i_rx, i_load_enable;
    logic [6:0]  o_mem_address;
    logic [31:0] o_mem_data;
    logic        o_mem_wren, o_core_reset, o_busy, o_error;

    always #5 clk = ~clk;

    instruction_loader #(
        .CLKS_PER_BIT (Cpb),
        .ADDR_WIDTH   (7),
        .XLEN         (32)
    ) dut (
        .i_clock       (i_reset === 1'bx ? 1'b0 : clk),
        .i_reset       (i_reset),
        .i_rx          (i_rx),
        .i_load_enable (i_load_enable),
        .o_mem_address (o_mem_address),
        .o_mem_data    (o_mem_data),
        .o_mem_wren    (o_mem_wren),
        .o_core_reset  (o_core_reset),
        .o_busy        (o_busy),
        .o_error       (o_error)
    );

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int              n;
        logic [0:11][7:0] b;
        int              bad_stop;
        logic            le;
        int              nwr;
        logic [31:0]     w0;
        logic [31:0]     w1;
        logic            err;
        logic            cr;
    } vec_t;

    wr_t   q[$];
    int    n_vec = 0;
    int    n_err = 0;
    vec_t  v[9];
    string names[9];
    logic  prev_cr;
    int    waited;
    logic [7:0] cs;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endfunction

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (o_mem_wren === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h want none",
                         o_mem_address, o_mem_data);
            end else begin
                wr_t w;
                w = q.pop_front();
                check("wr_addr", 32'(o_mem_address), 32'(w.a));
                check("wr_data", o_mem_data, w.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop, input int idle_bits);
        i_rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (Cpb) @(negedge clk);
        end
        i_rx = stop;
        repeat (Cpb) @(negedge clk);
        i_rx = 1'b1;
        repeat (idle_bits * Cpb) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, 32'(o_mem_address), 32'd0);
        check({tag, "_data"}, o_mem_data, 32'd0);
        check({tag, "_wren"}, 32'(o_mem_wren), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_error"}, 32'(o_error), 32'd0);
        check({tag, "_core_reset"}, 32'(o_core_reset), 32'd1);
    endtask

    task automatic send_good_frame();
        q.push_back('{a: 7'd0, d: 32'h00000013});
        q.push_back('{a: 7'd1, d: 32'h00100093});
        send_byte(8'hA5, 1'b1, 2);
        send_byte(8'h02, 1'b1, 2);
        send_byte(8'h13, 1'b1, 2);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h93, 1'b1, 2);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h10, 1'b1, 2);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h90, 1'b1, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        v[0] = '{n: 11, b: {8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                 8'h90, 8'h00}, bad_stop: -1, le: 1'b1, nwr: 2, w0: 32'h13, w1: 32'h00100093,
                 err: 1'b0, cr: 1'b0};
        v[1] = v[0];
        v[1].b[10] = 8'h91;
        v[1].err = 1'b1;
        v[1].cr = 1'b1;
        v[2] = v[0];
        v[3] = '{n: 2, b: {8'hA5, 8'h00, 80'h0}, bad_stop: -1, le: 1'b1, nwr: 0, w0: 32'h0,
                 w1: 32'h0, err: 1'b1, cr: 1'b1};
        v[4] = v[3];
        v[4].b[1] = 8'h81;
        v[5] = '{n: 5, b: {8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 56'h0}, bad_stop: 4, le: 1'b1,
                 nwr: 0, w0: 32'h0, w1: 32'h0, err: 1'b1, cr: 1'b1};
        v[6] = v[0];
        v[7] = '{n: 1, b: {8'h55, 88'h0}, bad_stop: -1, le: 1'b1, nwr: 0, w0: 32'h0,
                 w1: 32'h0, err: 1'b0, cr: 1'b0};
        v[8] = '{n: 1, b: {8'hA5, 88'h0}, bad_stop: -1, le: 1'b0, nwr: 0, w0: 32'h0,
                 w1: 32'h0, err: 1'b0, cr: 1'b0};
        names = '{"good", "bad_csum", "good_again", "len_zero", "len_over", "stop_err",
                  "after_stop_err", "junk_byte", "sync_disabled"};

        i_reset = 1'b0;
        i_rx = 1'b1;
        i_load_enable = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        i_reset = 1'b1;
        @(negedge clk);
        check("por_release_core_reset", 32'(o_core_reset), 32'd0);
        repeat (4) @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            i_load_enable = v[k].le;
            if (v[k].nwr >= 1) q.push_back('{a: 7'd0, d: v[k].w0});
            if (v[k].nwr >= 2) q.push_back('{a: 7'd1, d: v[k].w1});
            for (int j = 0; j < v[k].n; j++) send_byte(v[k].b[j], j != v[k].bad_stop, 2);
            repeat (10) @(negedge clk);
            check({names[k], "_error"}, 32'(o_error), 32'(v[k].err));
            check({names[k], "_core_reset"}, 32'(o_core_reset), 32'(v[k].cr));
            check({names[k], "_busy"}, 32'(o_busy), 32'd0);
            check({names[k], "_writes_left"}, 32'(q.size()), 32'd0);
            i_load_enable = 1'b1;
        end

        // Reset in the middle of a word: nothing written, next frame restarts at address 0.
        send_byte(8'hA5, 1'b1, 2);
        send_byte(8'h02, 1'b1, 2);
        send_byte(8'h13, 1'b1, 2);
        send_byte(8'h00, 1'b1, 2);
        i_reset = 1'b0;
        @(negedge clk);
        check_reset_values("midframe");
        i_reset = 1'b1;
        repeat (20) @(negedge clk);
        check("midframe_after_busy", 32'(o_busy), 32'd0);
        send_good_frame();
        repeat (10) @(negedge clk);
        check("refill_error", 32'(o_error), 32'd0);
        check("refill_core_reset", 32'(o_core_reset), 32'd0);
        check("refill_writes_left", 32'(q.size()), 32'd0);

        // Maximum-length frame: 128 words fill the whole memory.
        cs = 8'h00;
        send_byte(8'hA5, 1'b1, 2);
        send_byte(8'h80, 1'b1, 2);
        check("max_busy_mid", 32'(o_busy), 32'd1);
        check("max_core_reset_mid", 32'(o_core_reset), 32'd1);
        for (int i = 0; i < 128; i++) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = 8'(i);
            b1 = 8'h5A;
            b2 = ~8'(i);
            b3 = 8'(i + 1);
            q.push_back('{a: 7'(i), d: {b3, b2, b1, b0}});
            cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
            send_byte(b0, 1'b1, 1);
            send_byte(b1, 1'b1, 1);
            send_byte(b2, 1'b1, 1);
            send_byte(b3, 1'b1, 1);
        end
        send_byte(cs, 1'b1, 0);
        waited = 0;
        prev_cr = o_core_reset;
        while (o_busy && waited < 200) begin
            prev_cr = o_core_reset;
            @(negedge clk);
            waited++;
        end
        check("max_busy_fall", 32'(o_busy), 32'd0);
        check("max_core_reset_before", 32'(prev_cr), 32'd1);
        check("max_core_reset_after", 32'(o_core_reset), 32'd0);
        check("max_error", 32'(o_error), 32'd0);
        repeat (5) @(negedge clk);
        check("max_writes_left", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Serial program loader that writes RV32I machine code into the instruction memory over a UART link. It is the write side of the instruction memory, which the core itself only ever reads. It receives an 8N1 byte stream, assembles little-endian 32-bit words and issues one write per word, holding the core in reset from frame start until a checksum-verified frame completes. It sits beside the core at top level, with its write port muxed onto the instruction-memory data/address/wren inputs.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4
- ADDR_WIDTH, 7, instruction-memory word-address width; depth = 2^ADDR_WIDTH words
- XLEN, 32, instruction word width
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low (0 = reset), sampled on rising edge of clock
- rx  input  1  UART serial in, idle high, asynchronous to clock
- load_enable  input  1  1 = frames accepted; 0 = bytes ignored while in IDLE
- mem_address  output  ADDR_WIDTH  word address of current write
- mem_data  output  XLEN  word being written
- mem_wren  output  1  one-cycle write strobe
- core_reset  output  1  active-high reset to the core
- busy  output  1  frame in progress (state != IDLE)
- error  output  1  sticky fault flag, cleared by reset or next accepted sync byte

## Operation
- rx passes through a 2-flop synchronizer before any use.
- Byte receiver:
  - Start is detected on a synced falling edge in idle.
  - Start bit re-checked at CLKS_PER_BIT/2; if high, treated as a glitch and ignored.
  - Data bits sampled every CLKS_PER_BIT thereafter, LSB first; then the stop bit.
  - Stop = 1: byte_valid pulses for one cycle.
  - Stop = 0: framing error.
- Frame format: 0xA5 sync, length byte N (words), 4N data bytes (byte 0 = bits 7:0), checksum byte = XOR of all 4N data bytes.
- FSM states:
  - IDLE: byte 0xA5 with load_enable=1 -> LEN, clears error and the checksum accumulator. Any other byte is ignored.
  - LEN: N=0 or N>2^ADDR_WIDTH -> error=1, IDLE. Otherwise latch N -> DATA.
  - DATA: shift each byte into the word register and XOR it into the checksum. On the 4th byte of a word, pulse mem_wren and increment the word counter. After word N -> CHECK.
  - CHECK: if the received byte equals the accumulator -> IDLE with error=0; else -> IDLE with error=1.
- Framing error in any non-IDLE state: error=1, IDLE.
- Addressing: mem_address = 0 for the first word of every frame, +1 per write. No wrap is possible because N is bounded.
- core_reset:
  - 1 while reset is asserted, and from the sync-byte cycle until a frame ends with a good checksum.
  - On a bad checksum, length error or framing error it stays 1 until a later frame succeeds.
  - After reset with no frame received, it is 0, so the core runs the preloaded image.
- Bytes arriving in CHECK after the checksum byte are processed by IDLE rules.

## Timing
- Reset values: mem_address 0, mem_data 0, mem_wren 0, busy 0, error 0, core_reset 1. core_reset falls in the first cycle after reset deasserts.
- byte_valid occurs (sync delay 2) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the rx falling edge on the pin.
- mem_wren is high in the cycle after byte_valid of a word's 4th byte. mem_address and mem_data are stable in that same cycle and hold until the next write.
- core_reset deasserts, busy falls, and error updates in the cycle after the checksum byte_valid.
- Reset asserted mid-frame: all state returns to reset values at the next edge. Partial words are never written.
- load_enable is sampled only in IDLE. Dropping it mid-frame has no effect.

## Test plan
- CLKS_PER_BIT=4. Frame A5 02, bytes 13 00 00 00 93 00 10 00, checksum 0x90:
  - mem_wren pulses twice: (0, 0x00000013) then (1, 0x00100093).
  - core_reset falls one cycle after the checksum byte_valid; error=0.
- Same frame with checksum 0x91: both writes occur, error=1, core_reset stays 1. A following good frame clears error and releases core_reset.
- Length byte 0x00, then separately length 0x81 (ADDR_WIDTH=7): no mem_wren, error=1, busy returns to 0.
- Stop bit forced 0 on the 3rd data byte: no write for that word, error=1, FSM back in IDLE. The next A5 is accepted.
- Byte 0x55, then A5 with load_enable=0: busy stays 0, core_reset stays 0.
- Reset pulled low for 1 cycle after 2 data bytes: all outputs at reset values, no mem_wren. Next full frame writes from address 0.
